fpu_div: RTL and testbench

FPU_DIV -- requirements
Module: fpu_div

---
 rtl/fpu_div.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fpu_div.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div.sv
// -----------------------------------------------------------------------------
// fpu_div -- multi-cycle floating-point divider (restoring algorithm).
//
// Number format: sign (1 = positive, 0 = negative), 7-bit two's-complement
// exponent, 15-bit normalized mantissa (bit 14 = 1, value m / 2^14).
// Exponent -64 encodes zero and +63 encodes infinity; both special results
// carry mantissa 15'h4000.
//
// Every operation takes the same time: idle is low for exactly 18 cycles
// (PREP, 15 x ITER, EXP, FIN) after the edge that samples div in IDLE.
//
// Ports
//   clk                         rising-edge clock
//   reset                       synchronous, active-high reset
//   div                         start request, sampled only in IDLE
//   reg1_s / reg1_e / reg1_m    dividend sign / exponent / mantissa
//   reg2_s / reg2_e / reg2_m    divisor  sign / exponent / mantissa
//   res_s / res_e / res_m       registered quotient, updated only in FIN
//   zero_flag, overflow_flag,
//   underflow_flag,
//   div_zero_flag, invalid_flag registered status, updated only in FIN
//   idle                        high only while in IDLE
// -----------------------------------------------------------------------------
module fpu_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        div,
  input  logic        reg1_s,
  input  logic [6:0]  reg1_e,
  input  logic [14:0] reg1_m,
  input  logic        reg2_s,
  input  logic [6:0]  reg2_e,
  input  logic [14:0] reg2_m,
  output logic        res_s,
  output logic [6:0]  res_e,
  output logic [14:0] res_m,
  output logic        zero_flag,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        div_zero_flag,
  output logic        invalid_flag,
  output logic        idle
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_EXP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [6:0]  EXP_ZERO     = 7'b1000000;
  localparam logic [6:0]  EXP_INF      = 7'b0111111;
  localparam logic [14:0] MANT_SPECIAL = 15'h4000;
  localparam logic [3:0]  LAST_STEP    = 4'd14;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic underflow;
    logic div_zero;
    logic invalid;
  } flags_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state;
  logic [3:0]        step_cnt;

  // Latched operands (captured once per operation, in IDLE)
  logic              a_s, b_s;
  logic [6:0]        a_e, b_e;
  logic [14:0]       a_m, b_m;

  // Working datapath
  logic              sign_r;
  logic signed [8:0] exp_r;
  logic [16:0]       rem_r;
  logic [14:0]       quo_r;

  // Classified result waiting for FIN
  logic [6:0]        stage_e;
  logic [14:0]       stage_m;
  flags_t            stage_flags;
  flags_t            out_flags;

  assign idle = (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Restoring-division step: remainder minus divisor through a 17-bit adder
  // with the divisor inverted and carry-in 1. A carry out of bit 16 means the
  // subtraction did not borrow, i.e. remainder >= divisor.
  // ---------------------------------------------------------------------------
  logic [17:0] step_sum;
  logic        step_ge;
  logic [16:0] step_rem;
  logic [16:0] step_rem_shl;

  assign step_sum     = {1'b0, rem_r} + {1'b0, ~{2'b00, b_m}} + 18'd1;
  assign step_ge      = step_sum[17];
  assign step_rem     = step_ge ? step_sum[16:0] : rem_r;
  assign step_rem_shl = step_rem << 1;

  // ---------------------------------------------------------------------------
  // Preparation: pre-shift the dividend when m1 < m2 so the first quotient
  // bit is always 1, and compensate in the exponent.
  // ---------------------------------------------------------------------------
  logic              prep_lt;
  logic signed [8:0] prep_exp;

  assign prep_lt  = (a_m < b_m);
  assign prep_exp = $signed({{2{a_e[6]}}, a_e}) - $signed({{2{b_e[6]}}, b_e})
                    - $signed({8'd0, prep_lt});

  // ---------------------------------------------------------------------------
  // Result classification (consumed in EXP); special operands win over the
  // computed exponent, in strict priority order.
  // ---------------------------------------------------------------------------
  logic        a_zero, a_inf, b_zero, b_inf;
  logic [6:0]  cls_e;
  logic [14:0] cls_m;
  flags_t      cls_flags;

  assign a_zero = (a_e == EXP_ZERO);
  assign a_inf  = (a_e == EXP_INF);
  assign b_zero = (b_e == EXP_ZERO);
  assign b_inf  = (b_e == EXP_INF);

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cls_e     = exp_r[6:0];
    cls_m     = quo_r;
    cls_flags = '0;
    if (a_zero && b_zero) begin
      cls_flags.invalid = 1'b1;
      cls_e             = EXP_ZERO;
      cls_m             = MANT_SPECIAL;
    end else if (a_inf && b_inf) begin
      cls_flags.invalid = 1'b1;
      cls_e             = EXP_INF;
      cls_m             = MANT_SPECIAL;
    end else if (b_zero) begin
      cls_flags.div_zero = 1'b1;
      cls_e              = EXP_INF;
      cls_m              = MANT_SPECIAL;
    end else if (a_inf) begin
      cls_e = EXP_INF;
      cls_m = MANT_SPECIAL;
    end else if (a_zero || b_inf) begin
      cls_flags.zero = 1'b1;
      cls_e          = EXP_ZERO;
      cls_m          = MANT_SPECIAL;
    end else if (exp_r > 9'sd62) begin
      cls_flags.overflow = 1'b1;
      cls_e              = EXP_INF;
      cls_m              = MANT_SPECIAL;
    end else if (exp_r < -9'sd63) begin
      cls_flags.underflow = 1'b1;
      cls_flags.zero      = 1'b1;
      cls_e               = EXP_ZERO;
      cls_m               = MANT_SPECIAL;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. Reset wins over div; an operation in flight is simply
  // abandoned because outputs only move in FIN.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      step_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (div) state <= S_PREP;
        S_PREP: begin
          state    <= S_ITER;
          step_cnt <= '0;
        end
        S_ITER: begin
          step_cnt <= step_cnt + 4'd1;
          if (step_cnt == LAST_STEP) state <= S_EXP;
        end
        S_EXP:   state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath.
  // ---------------------------------------------------------------------------
  // NOTE: these registers are deliberately not reset: each is fully written
  // in IDLE/PREP before it is read, and nothing reaches the outputs until FIN.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (div) begin
          a_s <= reg1_s;
          a_e <= reg1_e;
          a_m <= reg1_m;
          b_s <= reg2_s;
          b_e <= reg2_e;
          b_m <= reg2_m;
        end
      end
      S_PREP: begin
        sign_r <= (a_s == b_s);
        exp_r  <= prep_exp;
        rem_r  <= prep_lt ? {1'b0, a_m, 1'b0} : {2'b00, a_m};
        quo_r  <= '0;
      end
      S_ITER: begin
        rem_r <= step_rem_shl;
        // Quotient bits enter at the LSB; after 15 steps the first one sits
        // in bit 14.
        quo_r <= {quo_r[13:0], step_ge};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result staging and output registers. Pending flags are cleared in PREP
  // and loaded in EXP; the visible outputs only change together in FIN and
  // hold until the next FIN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_e     <= '0;
      stage_m     <= '0;
      stage_flags <= '0;
      res_s       <= 1'b0;
      res_e       <= '0;
      res_m       <= '0;
      out_flags   <= '0;
    end else begin
      case (state)
        S_PREP: stage_flags <= '0;
        S_EXP: begin
          stage_e     <= cls_e;
          stage_m     <= cls_m;
          stage_flags <= cls_flags;
        end
        S_FIN: begin
          res_s     <= sign_r;
          res_e     <= stage_e;
          res_m     <= stage_m;
          out_flags <= stage_flags;
        end
        default: ;
      endcase
    end
  end

  assign zero_flag      = out_flags.zero;
  assign overflow_flag  = out_flags.overflow;
  assign underflow_flag = out_flags.underflow;
  assign div_zero_flag  = out_flags.div_zero;
  assign invalid_flag   = out_flags.invalid;

endmodule

// File: tb/tb_fpu_div.sv
// -----------------------------------------------------------------------------
// tb_fpu_div -- self-checking bench for fpu_div.
// Directed scenarios plus randomized operands, compared against a reference
// model that divides mantissas with plain integer arithmetic and applies the
// special-value priority rules directly.
// -----------------------------------------------------------------------------
module tb_fpu_div;

  typedef struct packed {
    logic        s;
    logic [6:0]  e;
    logic [14:0] m;
  } op_t;

  localparam logic [6:0] E_ZERO = 7'b1000000;
  localparam logic [6:0] E_INF  = 7'b0111111;
  localparam int         BUSY_CYCLES = 18;
  localparam int         BUSY_LIMIT  = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        div;
  logic        reg1_s, reg2_s;
  logic [6:0]  reg1_e, reg2_e;
  logic [14:0] reg1_m, reg2_m;
  logic        res_s;
  logic [6:0]  res_e;
  logic [14:0] res_m;
  logic        zero_flag, overflow_flag, underflow_flag, div_zero_flag, invalid_flag;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_div dut (
    .clk            (clk),
    .reset          (reset),
    .div            (div),
    .reg1_s         (reg1_s),
    .reg1_e         (reg1_e),
    .reg1_m         (reg1_m),
    .reg2_s         (reg2_s),
    .reg2_e         (reg2_e),
    .reg2_m         (reg2_m),
    .res_s          (res_s),
    .res_e          (res_e),
    .res_m          (res_m),
    .zero_flag      (zero_flag),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .div_zero_flag  (div_zero_flag),
    .invalid_flag   (invalid_flag),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_res();
    return {9'd0, res_s, res_e, res_m};
  endfunction

  function automatic logic [31:0] obs_flags();
    return {27'd0, zero_flag, overflow_flag, underflow_flag, div_zero_flag, invalid_flag};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: value = m / 2^14 * 2^e. The truncated quotient mantissa
  // is floor(m1 * 2^14 / m2), or floor(m1 * 2^15 / m2) with the exponent one
  // lower when m1 < m2 so that the result stays in [1, 2).
  // flags packed as {zero, overflow, underflow, div_zero, invalid}.
  // ---------------------------------------------------------------------------
  function automatic void model(input op_t a, input op_t b,
                                output logic [31:0] res, output logic [31:0] flags);
    logic        sg;
    logic [6:0]  re;
    logic [14:0] rm;
    logic [4:0]  f;
    int          ex;
    longint      q;
    logic        z1, z2, i1, i2;
    z1 = (a.e == E_ZERO);
    z2 = (b.e == E_ZERO);
    i1 = (a.e == E_INF);
    i2 = (b.e == E_INF);
    sg = (a.s == b.s);
    f  = 5'b0;
    rm = 15'h4000;
    if (z1 && z2)      begin f = 5'b00001; re = E_ZERO; end
    else if (i1 && i2) begin f = 5'b00001; re = E_INF;  end
    else if (z2)       begin f = 5'b00010; re = E_INF;  end
    else if (i1)       begin re = E_INF; end
    else if (z1 || i2) begin f = 5'b10000; re = E_ZERO; end
    else begin
      ex = int'($signed(a.e)) - int'($signed(b.e));
      if (a.m >= b.m) q = (longint'(a.m) * 16384) / longint'(b.m);
      else begin
        q  = (longint'(a.m) * 32768) / longint'(b.m);
        ex = ex - 1;
      end
      if (ex > 62)       begin f = 5'b01000; re = E_INF;  end
      else if (ex < -63) begin f = 5'b10100; re = E_ZERO; end
      else begin
        re = ex[6:0];
        rm = q[14:0];
      end
    end
    res   = {9'd0, sg, re, rm};
    flags = {27'd0, f};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic op_t rand_op();
    op_t o;
    int  v;
    int  r;
    o.s = 1'($urandom);
    o.m = {1'b1, 14'($urandom)};
    r   = int'($urandom_range(0, 9));
    case (r)
      0:       o.e = E_ZERO;
      1:       o.e = E_INF;
      2:       o.e = ($urandom % 2 == 0) ? 7'd62 : 7'b1000001;
      default: begin
        v   = int'($urandom_range(0, 125)) - 63;
        o.e = v[6:0];
      end
    endcase
    return o;
  endfunction

  task automatic drive(input op_t a, input op_t b);
    reg1_s = a.s; reg1_e = a.e; reg1_m = a.m;
    reg2_s = b.s; reg2_e = b.e; reg2_m = b.m;
  endtask

  // Called #1 after the edge that sampled div; counts cycles with idle low.
  task automatic wait_done(input string tag);
    int busy;
    busy = 0;
    while (!idle && busy < BUSY_LIMIT) begin
      busy++;
      @(posedge clk);
      #1;
    end
    check({tag, " latency"}, 32'(busy), 32'(BUSY_CYCLES));
  endtask

  task automatic check_result(input string tag, input op_t a, input op_t b);
    logic [31:0] er, ef;
    model(a, b, er, ef);
    check({tag, " result"}, obs_res(), er);
    check({tag, " flags"}, obs_flags(), ef);
  endtask

  // One complete operation; operands are scrambled right after sampling.
  task automatic do_op(input string tag, input op_t a, input op_t b);
    @(negedge clk);
    drive(a, b);
    div = 1'b1;
    @(posedge clk);
    #1;
    div = 1'b0;
    drive(rand_op(), rand_op());
    wait_done(tag);
    check_result(tag, a, b);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  op_t six, two, one, three_n, five, zero, big, quarter, tiny, two_p;
  op_t ops[5];

  initial begin
    six     = {1'b1, 7'd2, 15'h6000};
    two     = {1'b1, 7'd1, 15'h4000};
    one     = {1'b1, 7'd0, 15'h4000};
    three_n = {1'b0, 7'd1, 15'h6000};
    five    = {1'b1, 7'd2, 15'h5000};
    zero    = {1'b1, E_ZERO, 15'h4000};
    big     = {1'b1, 7'd62, 15'h6000};
    quarter = {1'b1, 7'b1111110, 15'h4000};
    tiny    = {1'b1, 7'b1000001, 15'h4000};
    two_p   = {1'b1, 7'd1, 15'h4000};

    // Reset asserted together with div: reset must win.
    reset = 1'b1;
    div   = 1'b1;
    drive(six, two);
    repeat (2) @(posedge clk);
    #1;
    check("reset idle", 32'(idle), 32'd1);
    check("reset result", obs_res(), 32'd0);
    check("reset flags", obs_flags(), 32'd0);
    @(negedge clk);
    div   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle after reset", 32'(idle), 32'd1);

    // Directed scenarios
    do_op("6/2", six, two);
    check("6/2 literal", obs_res(), {9'd0, 1'b1, 7'd1, 15'h6000});
    do_op("1/-3", one, three_n);
    check("1/-3 literal", obs_res(), {9'd0, 1'b0, 7'b1111110, 15'h5555});
    do_op("5/0", five, zero);
    check("5/0 div_zero", 32'(div_zero_flag), 32'd1);
    do_op("0/0", zero, zero);
    check("0/0 invalid", 32'(invalid_flag), 32'd1);
    do_op("overflow", big, quarter);
    check("overflow exp", 32'(res_e), 32'(E_INF));
    do_op("underflow", tiny, two_p);
    check("underflow exp", 32'(res_e), 32'(E_ZERO));

    // Outputs hold while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold result", obs_res(), {9'd0, 1'b1, E_ZERO, 15'h4000});

    // Back-to-back with div held high; operands for the next op are driven
    // while the current one is still iterating.
    for (int k = 0; k < 5; k++) ops[k] = rand_op();
    ops[0] = six;
    @(negedge clk);
    drive(ops[0], two);
    div = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) div = 1'b0;
      drive(ops[k + 1], two);
      wait_done($sformatf("b2b%0d", k));
      check_result($sformatf("b2b%0d", k), ops[k], two);
    end

    // Reset in ITER cycle 7 aborts the operation.
    @(negedge clk);
    drive(one, three_n);
    div = 1'b1;
    @(posedge clk);
    #1;
    div = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort still busy", 32'(idle), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort idle", 32'(idle), 32'd1);
    check("abort result", obs_res(), 32'd0);
    check("abort flags", obs_flags(), 32'd0);
    do_op("after abort", six, two);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), rand_op(), rand_op());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
